// File: rtl/read_threshold_pkg.sv
// Shared definitions for the read_threshold frame source: FSM encoding,
// pixel-pair field layout and the per-pixel binary threshold.
package read_threshold_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_HBLANK,
        ST_ROW,
        ST_DRAIN
    } state_t;

    localparam int PIXEL_W   = 24;
    localparam int EVEN_LSB  = 24;
    localparam int ODD_LSB   = 0;
    localparam int RED_LSB   = 16;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 0;

    // Gray is approximated by R+G+B against 3*thr; ties resolve to black.
    function automatic logic [23:0] threshold_pixel(input logic [23:0] rgb,
                                                    input logic [7:0]  thr);
        logic [9:0] sum;
        logic [9:0] limit;
        sum   = {2'b00, rgb[RED_LSB +: 8]} + {2'b00, rgb[GREEN_LSB +: 8]}
              + {2'b00, rgb[BLUE_LSB +: 8]};
        limit = 10'd3 * {2'b00, thr};
        return (sum > limit) ? 24'hFF_FFFF : 24'h00_0000;
    endfunction

endpackage

// File: rtl/pixel_threshold.sv
// Registered two-pixel threshold stage; carries the pair-valid flag so the
// pulse and the data it qualifies leave on the same cycle.
module pixel_threshold
    import read_threshold_pkg::*;
#(
    parameter int THRESHOLD = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [47:0] pair_in,
    output logic        horizontal_Pulse,
    output logic [7:0]  data_Red_Even,
    output logic [7:0]  data_Green_Even,
    output logic [7:0]  data_Blue_Even,
    output logic [7:0]  data_Red_Odd,
    output logic [7:0]  data_Green_Odd,
    output logic [7:0]  data_Blue_Odd
);

    logic [23:0] even_px;
    logic [23:0] odd_px;

    always_comb begin
        even_px = threshold_pixel(pair_in[EVEN_LSB +: PIXEL_W], 8'(THRESHOLD));
        odd_px  = threshold_pixel(pair_in[ODD_LSB +: PIXEL_W], 8'(THRESHOLD));
    end

    // Data is forced to zero outside valid pairs so blanking never leaks memory contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            horizontal_Pulse <= 1'b0;
            data_Red_Even    <= 8'd0;
            data_Green_Even  <= 8'd0;
            data_Blue_Even   <= 8'd0;
            data_Red_Odd     <= 8'd0;
            data_Green_Odd   <= 8'd0;
            data_Blue_Odd    <= 8'd0;
        end else begin
            horizontal_Pulse <= valid_in;
            if (valid_in) begin
                data_Red_Even   <= even_px[RED_LSB +: 8];
                data_Green_Even <= even_px[GREEN_LSB +: 8];
                data_Blue_Even  <= even_px[BLUE_LSB +: 8];
                data_Red_Odd    <= odd_px[RED_LSB +: 8];
                data_Green_Odd  <= odd_px[GREEN_LSB +: 8];
                data_Blue_Odd   <= odd_px[BLUE_LSB +: 8];
            end else begin
                data_Red_Even   <= 8'd0;
                data_Green_Even <= 8'd0;
                data_Blue_Even  <= 8'd0;
                data_Red_Odd    <= 8'd0;
                data_Green_Odd  <= 8'd0;
                data_Blue_Odd   <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/read_threshold.sv
// Frame source: walks the frame memory pair by pair with row/frame timing
// and hands each word to the threshold stage two cycles after its address.
module read_threshold
    import read_threshold_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int THRESHOLD    = 90,
    parameter int H_BLANK      = 160,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_Addr,
    input  logic [47:0]           mem_Data,
    output logic                  vertical_Pulse,
    output logic                  horizontal_Pulse,
    output logic [7:0]            data_Red_Even,
    output logic [7:0]            data_Green_Even,
    output logic [7:0]            data_Blue_Even,
    output logic [7:0]            data_Red_Odd,
    output logic [7:0]            data_Green_Odd,
    output logic [7:0]            data_Blue_Odd,
    output logic                  sig_Read_Done
);

    localparam int PAIRS   = IMAGE_WIDTH / 2;
    localparam int PAIR_W  = $clog2(PAIRS + 1);
    localparam int ROW_W   = $clog2(IMAGE_HEIGHT + 1);
    localparam int BLANK_W = $clog2(H_BLANK + 1);

    localparam logic [PAIR_W-1:0]  LAST_PAIR  = PAIR_W'(PAIRS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [BLANK_W-1:0] LAST_BLANK = BLANK_W'(H_BLANK - 1);

    state_t               state;
    logic [PAIR_W-1:0]    pair_cnt;
    logic [ROW_W-1:0]     row_cnt;
    logic [BLANK_W-1:0]   blank_cnt;
    logic                 drain_cnt;
    logic                 row_d1;

    // row_d1 marks the cycle mem_Data answers a ROW address; DRAIN lets the last two pairs leave.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            pair_cnt       <= '0;
            row_cnt        <= '0;
            blank_cnt      <= '0;
            drain_cnt      <= 1'b0;
            row_d1         <= 1'b0;
            mem_Addr       <= '0;
            vertical_Pulse <= 1'b0;
            sig_Read_Done  <= 1'b0;
        end else begin
            vertical_Pulse <= 1'b0;
            row_d1         <= (state == ST_ROW);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_VSYNC;
                        vertical_Pulse <= 1'b1;
                        sig_Read_Done  <= 1'b0;
                        mem_Addr       <= '0;
                        pair_cnt       <= '0;
                        row_cnt        <= '0;
                    end
                end
                ST_VSYNC: begin
                    state     <= ST_HBLANK;
                    blank_cnt <= '0;
                end
                ST_HBLANK: begin
                    if (blank_cnt == LAST_BLANK) begin
                        state <= ST_ROW;
                    end else begin
                        blank_cnt <= blank_cnt + BLANK_W'(1);
                    end
                end
                ST_ROW: begin
                    mem_Addr <= mem_Addr + ADDR_WIDTH'(1);
                    if (pair_cnt == LAST_PAIR) begin
                        pair_cnt <= '0;
                        if (row_cnt == LAST_ROW) begin
                            row_cnt   <= '0;
                            drain_cnt <= 1'b0;
                            state     <= ST_DRAIN;
                        end else begin
                            row_cnt   <= row_cnt + ROW_W'(1);
                            blank_cnt <= '0;
                            state     <= ST_HBLANK;
                        end
                    end else begin
                        pair_cnt <= pair_cnt + PAIR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        sig_Read_Done <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pixel_threshold #(
        .THRESHOLD (THRESHOLD)
    ) u_pixel_threshold (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (row_d1),
        .pair_in          (mem_Data),
        .horizontal_Pulse (horizontal_Pulse),
        .data_Red_Even    (data_Red_Even),
        .data_Green_Even  (data_Green_Even),
        .data_Blue_Even   (data_Blue_Even),
        .data_Red_Odd     (data_Red_Odd),
        .data_Green_Odd   (data_Green_Odd),
        .data_Blue_Odd    (data_Blue_Odd)
    );

endmodule

// File: tb/tb_read_threshold.sv
// Self-checking bench for read_threshold: two small-frame instances checked every
// cycle against a timing/threshold model, plus a full-size instance for mid-row reset.
module tb_read_threshold;

    localparam int W      = 8;
    localparam int H      = 2;
    localparam int HB     = 3;
    localparam int P      = W / 2;
    localparam int DONE_O = 4 + H * (HB + P);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a = 1'b1;
    logic start_a = 1'b0;
    logic reset_b = 1'b1;
    logic start_b = 1'b0;

    logic [3:0]  addr_a, addr_c;
    logic [17:0] addr_b;
    logic [47:0] mem_data_a, mem_data_b, mem_data_c;
    logic        vp_a, hp_a, done_a, vp_b, hp_b, done_b, vp_c, hp_c, done_c;
    logic [7:0]  re_a, ge_a, be_a, ro_a, go_a, bo_a;
    logic [7:0]  re_b, ge_b, be_b, ro_b, go_b, bo_b;
    logic [7:0]  re_c, ge_c, be_c, ro_c, go_c, bo_c;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int st_a  = -1;

    read_threshold #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .THRESHOLD(30), .H_BLANK(HB), .ADDR_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .mem_Addr(addr_a), .mem_Data(mem_data_a),
        .vertical_Pulse(vp_a), .horizontal_Pulse(hp_a),
        .data_Red_Even(re_a), .data_Green_Even(ge_a), .data_Blue_Even(be_a),
        .data_Red_Odd(ro_a), .data_Green_Odd(go_a), .data_Blue_Odd(bo_a),
        .sig_Read_Done(done_a));

    read_threshold #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .THRESHOLD(255), .H_BLANK(HB), .ADDR_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset_a), .start(start_a), .mem_Addr(addr_c), .mem_Data(mem_data_c),
        .vertical_Pulse(vp_c), .horizontal_Pulse(hp_c),
        .data_Red_Even(re_c), .data_Green_Even(ge_c), .data_Blue_Even(be_c),
        .data_Red_Odd(ro_c), .data_Green_Odd(go_c), .data_Blue_Odd(bo_c),
        .sig_Read_Done(done_c));

    read_threshold dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .mem_Addr(addr_b), .mem_Data(mem_data_b),
        .vertical_Pulse(vp_b), .horizontal_Pulse(hp_b),
        .data_Red_Even(re_b), .data_Green_Even(ge_b), .data_Blue_Even(be_b),
        .data_Red_Odd(ro_b), .data_Green_Odd(go_b), .data_Blue_Odd(bo_b),
        .sig_Read_Done(done_b));

    // Word 0 is the threshold boundary pair; the rest is a byte ramp.
    function automatic logic [47:0] mem_word(input int a);
        logic [47:0] w;
        if (a == 0) return {8'd30, 8'd30, 8'd30, 8'd31, 8'd30, 8'd30};
        for (int j = 0; j < 6; j++) w[47 - 8*j -: 8] = 8'((a * 7 + j * 3) & 255);
        return w;
    endfunction

    function automatic logic [47:0] exp_pair(input int n, input int thr);
        logic [47:0] w;
        logic [47:0] r;
        int s;
        w = mem_word(n);
        for (int p = 0; p < 2; p++) begin
            s = int'(w[47 - 24*p -: 8]) + int'(w[39 - 24*p -: 8]) + int'(w[31 - 24*p -: 8]);
            r[47 - 24*p -: 24] = (s > 3 * thr) ? 24'hFF_FFFF : 24'h00_0000;
        end
        return r;
    endfunction

    // Pair index whose address is issued at frame offset o, or -1 outside ROW.
    function automatic int slot_of(input int o);
        int rel, r, c;
        if (o < 2) return -1;
        rel = o - 2;
        r   = rel / (HB + P);
        c   = rel % (HB + P);
        if (r >= H || c < HB) return -1;
        return r * P + c - HB;
    endfunction

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic apply_stimulus_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 100; i++) begin
            if (done_a) break;
            @(negedge clk);
        end
        check_output("done_timeout_a", done_a, 1);
    endtask

    always @(posedge clk) begin
        mem_data_a <= mem_word(int'(addr_a));
        mem_data_c <= mem_word(int'(addr_c));
        mem_data_b <= mem_word(int'(addr_b));
    end

    // Frame offset bookkeeping: a start is honoured only when no frame is running.
    always @(posedge clk) begin
        if (!reset_a) st_a <= -1;
        else if (start_a && (st_a < 0 || cyc - st_a >= DONE_O)) st_a <= cyc;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int o, sn, hn;
        o  = (st_a < 0) ? -1 : cyc - st_a;
        sn = (o < 0) ? -1 : slot_of(o);
        hn = (o < 0) ? -1 : slot_of(o - 2);
        check_output("vp_a", vp_a, (o == 1));
        check_output("hp_a", hp_a, (hn >= 0));
        check_output("done_a", done_a, (o >= DONE_O));
        check_output("data_a", {re_a, ge_a, be_a, ro_a, go_a, bo_a}, (hn >= 0) ? exp_pair(hn, 30) : 48'd0);
        check_output("hp_c", hp_c, (hn >= 0));
        check_output("data_c", {re_c, ge_c, be_c, ro_c, go_c, bo_c}, (hn >= 0) ? exp_pair(hn, 255) : 48'd0);
        check_output("done_c", done_c, (o >= DONE_O));
        if (sn >= 0) begin
            check_output("addr_a", addr_a, sn);
            check_output("addr_c", addr_c, sn);
        end
        if (o < 0) check_output("addr_idle_a", addr_a, 0);
        if (o == 7)  check_output("pin_word0", {re_a, ge_a, be_a, ro_a, go_a, bo_a}, 48'h000000_FFFFFF);
        if (o == 8)  check_output("pin_word1", {re_a, ge_a, be_a, ro_a, go_a, bo_a}, 48'h0);
        if (o == 13) check_output("pin_addr5", addr_a, 5);
        if (o == 15) begin
            check_output("pin_hp_word5", hp_a, 1);
            check_output("pin_word5", {re_a, ge_a, be_a, ro_a, go_a, bo_a}, 48'hFFFFFF_FFFFFF);
            check_output("pin_word5_thr255", {re_c, ge_c, be_c, ro_c, go_c, bo_c}, 48'h0);
        end
    end

    initial begin
        #1 reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_a", {vp_a, hp_a, done_a, addr_a, re_a, ge_a, be_a, ro_a, go_a, bo_a}, 0);
        reset_a = 1'b1;
        repeat (2) @(negedge clk);

        apply_stimulus_a();
        repeat (11) @(negedge clk);
        apply_stimulus_a();
        wait_done_a();

        apply_stimulus_a();
        check_output("b2b_done_drop", done_a, 0);
        check_output("b2b_vsync", vp_a, 1);
        wait_done_a();
        repeat (5) @(negedge clk);
        check_output("done_held", done_a, 1);

        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (addr_b == 18'd1252) break;
            @(negedge clk);
        end
        check_output("b_addr_row3_pair100", addr_b, 1252);
        check_output("b_hp_midrow", hp_b, 1);
        check_output("b_data_midrow", {re_b, ge_b, be_b, ro_b, go_b, bo_b}, exp_pair(1250, 90));
        #1 reset_b = 1'b0;
        #1;
        check_output("b_reset_ctrl", {vp_b, hp_b, done_b, addr_b}, 0);
        check_output("b_reset_data", {re_b, ge_b, be_b, ro_b, go_b, bo_b}, 0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_output("b_replay_vsync", vp_b, 1);
        repeat (160) @(negedge clk);
        check_output("b_replay_blank_addr", addr_b, 0);
        @(negedge clk);
        check_output("b_replay_first_addr", addr_b, 0);
        @(negedge clk);
        check_output("b_replay_second_addr", addr_b, 1);
        @(negedge clk);
        check_output("b_replay_hp", hp_b, 1);
        check_output("b_replay_data0", {re_b, ge_b, be_b, ro_b, go_b, bo_b}, exp_pair(0, 90));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
